// File: rtl/scaler_frame_sequencer.sv
// ---------------------------------------------------------------------------------------------
// scaler_frame_sequencer
//
// Frame-level controller for one streamScaler instance. The host writes a shadow copy of the
// scaler configuration and requests a commit; the commit is applied (shadow -> active) only on
// entry to START, so the active configuration never changes inside a frame. Each frame issues
// a one-cycle start pulse, waits a programmable number of cycles, then paces read-out with
// nextDout in line windows separated by programmable H-blank gaps. Accepted pixels
// (dOutValid & nextDout) are counted and the last pixel of the frame raises frameDone.
//
// Ports
//   i_clk                rising-edge clock
//   i_rst_n              synchronous reset, active low
//   i_cfg_write          write i_cfg_data into shadow register i_cfg_addr
//   i_cfg_addr           0 discard, 1 inXRes, 2 inYRes, 3 outXRes, 4 outYRes, 5 xScale,
//                        6 yScale, 7 leftOffset, 8 topFracOffset, 9 nearestNeighbor,
//                        10 startWait, 11 hBlank; 12-15 ignored
//   i_cfg_data           write data, LSB-aligned, truncated to register width
//   i_cfg_commit         request shadow -> active copy at next frame start
//   i_run                level; run frames back to back while high
//   i_d_out_valid        scaler output valid
//   o_scaler_start       one-cycle start pulse to the scaler
//   o_input_discard_cnt .. o_nearest_neighbor   active configuration to the scaler
//   o_next_dout          read request to the scaler (registered)
//   o_frame_done         one-cycle pulse coincident with the last accepted pixel
//   o_busy               high in every state except IDLE
//   o_commit_pending     commit requested but not yet applied
// ---------------------------------------------------------------------------------------------
module scaler_frame_sequencer #(
   parameter int unsigned DISCARD_CNT_WIDTH  = 8,
   parameter int unsigned INPUT_X_RES_WIDTH  = 11,
   parameter int unsigned INPUT_Y_RES_WIDTH  = 11,
   parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
   parameter int unsigned OUTPUT_Y_RES_WIDTH = 11,
   parameter int unsigned SCALE_WIDTH        = 18,
   parameter int unsigned BLANK_WIDTH        = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_cfg_write,
   input  logic [3:0]                      i_cfg_addr,
   input  logic [31:0]                     i_cfg_data,
   input  logic                            i_cfg_commit,
   input  logic                            i_run,
   input  logic                            i_d_out_valid,
   output logic                            o_scaler_start,
   output logic [DISCARD_CNT_WIDTH-1:0]    o_input_discard_cnt,
   output logic [INPUT_X_RES_WIDTH-1:0]    o_input_x_res,
   output logic [INPUT_Y_RES_WIDTH-1:0]    o_input_y_res,
   output logic [OUTPUT_X_RES_WIDTH-1:0]   o_output_x_res,
   output logic [OUTPUT_Y_RES_WIDTH-1:0]   o_output_y_res,
   output logic [SCALE_WIDTH-1:0]          o_x_scale,
   output logic [SCALE_WIDTH-1:0]          o_y_scale,
   output logic [INPUT_X_RES_WIDTH+13:0]   o_left_offset,
   output logic [SCALE_WIDTH-1:0]          o_top_frac_offset,
   output logic                            o_nearest_neighbor,
   output logic                            o_next_dout,
   output logic                            o_frame_done,
   output logic                            o_busy,
   output logic                            o_commit_pending
);

   localparam int unsigned LeftOffsetWidth = INPUT_X_RES_WIDTH + 14;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWait,
      StLine,
      StBlank,
      StDone
   } state_e;

   // Shadow (host-side) configuration
   logic [DISCARD_CNT_WIDTH-1:0]  r_sh_discard;
   logic [INPUT_X_RES_WIDTH-1:0]  r_sh_in_x;
   logic [INPUT_Y_RES_WIDTH-1:0]  r_sh_in_y;
   logic [OUTPUT_X_RES_WIDTH-1:0] r_sh_out_x;
   logic [OUTPUT_Y_RES_WIDTH-1:0] r_sh_out_y;
   logic [SCALE_WIDTH-1:0]        r_sh_x_scale;
   logic [SCALE_WIDTH-1:0]        r_sh_y_scale;
   logic [LeftOffsetWidth-1:0]    r_sh_left;
   logic [SCALE_WIDTH-1:0]        r_sh_top;
   logic                          r_sh_nn;
   logic [BLANK_WIDTH-1:0]        r_sh_start_wait;
   logic [BLANK_WIDTH-1:0]        r_sh_h_blank;

   // Active (frame-stable) configuration
   logic [DISCARD_CNT_WIDTH-1:0]  r_act_discard;
   logic [INPUT_X_RES_WIDTH-1:0]  r_act_in_x;
   logic [INPUT_Y_RES_WIDTH-1:0]  r_act_in_y;
   logic [OUTPUT_X_RES_WIDTH-1:0] r_act_out_x;
   logic [OUTPUT_Y_RES_WIDTH-1:0] r_act_out_y;
   logic [SCALE_WIDTH-1:0]        r_act_x_scale;
   logic [SCALE_WIDTH-1:0]        r_act_y_scale;
   logic [LeftOffsetWidth-1:0]    r_act_left;
   logic [SCALE_WIDTH-1:0]        r_act_top;
   logic                          r_act_nn;
   logic [BLANK_WIDTH-1:0]        r_act_start_wait;
   logic [BLANK_WIDTH-1:0]        r_act_h_blank;

   // Control state
   state_e                        r_state;
   logic                          r_commit_pending;
   logic                          r_cfg_valid;
   logic                          r_next_dout;
   logic [OUTPUT_X_RES_WIDTH-1:0] r_x_cnt;
   logic [OUTPUT_Y_RES_WIDTH-1:0] r_y_cnt;
   logic [BLANK_WIDTH-1:0]        r_tmr;    // shared by startup wait and H-blank

   state_e                        w_state_d;
   logic [OUTPUT_X_RES_WIDTH-1:0] w_x_cnt_d;
   logic [OUTPUT_Y_RES_WIDTH-1:0] w_y_cnt_d;
   logic [BLANK_WIDTH-1:0]        w_tmr_d;
   logic                          w_accept;
   logic                          w_apply;
   logic                          w_unused_cfg_data;

   // Upper data bits beyond the widest register are intentionally dropped.
   assign w_unused_cfg_data = ^i_cfg_data;

   assign w_accept = i_d_out_valid & r_next_dout;
   // START is only ever entered from IDLE or DONE, so this marks every entry into START.
   assign w_apply  = (w_state_d == StStart) & r_commit_pending;

   // Next-state and pulse outputs
   always_comb begin
      w_state_d      = r_state;
      w_x_cnt_d      = r_x_cnt;
      w_y_cnt_d      = r_y_cnt;
      w_tmr_d        = r_tmr;
      o_scaler_start = 1'b0;
      o_frame_done   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_run && (r_cfg_valid || r_commit_pending)) begin
               w_state_d = StStart;
            end
         end
         StStart: begin
            o_scaler_start = 1'b1;
            w_state_d      = StWait;
            w_tmr_d        = r_act_start_wait;
         end
         StWait: begin
            if (r_tmr == '0) begin
               w_state_d = StLine;
               w_x_cnt_d = '0;
            end else begin
               w_tmr_d = r_tmr - BLANK_WIDTH'(1);
            end
         end
         StLine: begin
            if (w_accept) begin
               if (r_x_cnt == r_act_out_x) begin
                  if (r_y_cnt == r_act_out_y) begin
                     w_state_d    = StDone;
                     o_frame_done = 1'b1;
                  end else begin
                     w_state_d = StBlank;
                     w_y_cnt_d = r_y_cnt + OUTPUT_Y_RES_WIDTH'(1);
                     w_x_cnt_d = '0;
                     w_tmr_d   = r_act_h_blank;
                  end
               end else begin
                  w_x_cnt_d = r_x_cnt + OUTPUT_X_RES_WIDTH'(1);
               end
            end
         end
         StBlank: begin
            if (r_tmr == '0) begin
               w_state_d = StLine;
            end else begin
               w_tmr_d = r_tmr - BLANK_WIDTH'(1);
            end
         end
         StDone: begin
            w_x_cnt_d = '0;
            w_y_cnt_d = '0;
            w_tmr_d   = '0;
            w_state_d = i_run ? StStart : StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state          <= StIdle;
         r_commit_pending <= 1'b0;
         r_cfg_valid      <= 1'b0;
         r_next_dout      <= 1'b0;
         r_x_cnt          <= '0;
         r_y_cnt          <= '0;
         r_tmr            <= '0;
         r_sh_discard     <= '0;
         r_sh_in_x        <= '0;
         r_sh_in_y        <= '0;
         r_sh_out_x       <= '0;
         r_sh_out_y       <= '0;
         r_sh_x_scale     <= '0;
         r_sh_y_scale     <= '0;
         r_sh_left        <= '0;
         r_sh_top         <= '0;
         r_sh_nn          <= 1'b0;
         r_sh_start_wait  <= '0;
         r_sh_h_blank     <= '0;
         r_act_discard    <= '0;
         r_act_in_x       <= '0;
         r_act_in_y       <= '0;
         r_act_out_x      <= '0;
         r_act_out_y      <= '0;
         r_act_x_scale    <= '0;
         r_act_y_scale    <= '0;
         r_act_left       <= '0;
         r_act_top        <= '0;
         r_act_nn         <= 1'b0;
         r_act_start_wait <= '0;
         r_act_h_blank    <= '0;
      end else begin
         r_state     <= w_state_d;
         r_x_cnt     <= w_x_cnt_d;
         r_y_cnt     <= w_y_cnt_d;
         r_tmr       <= w_tmr_d;
         r_next_dout <= (w_state_d == StLine);

         // A commit arriving on the apply edge stays pending for the following frame.
         if (i_cfg_commit) begin
            r_commit_pending <= 1'b1;
         end else if (w_apply) begin
            r_commit_pending <= 1'b0;
         end

         if (i_cfg_write) begin
            case (i_cfg_addr)
               4'd0:    r_sh_discard    <= i_cfg_data[DISCARD_CNT_WIDTH-1:0];
               4'd1:    r_sh_in_x       <= i_cfg_data[INPUT_X_RES_WIDTH-1:0];
               4'd2:    r_sh_in_y       <= i_cfg_data[INPUT_Y_RES_WIDTH-1:0];
               4'd3:    r_sh_out_x      <= i_cfg_data[OUTPUT_X_RES_WIDTH-1:0];
               4'd4:    r_sh_out_y      <= i_cfg_data[OUTPUT_Y_RES_WIDTH-1:0];
               4'd5:    r_sh_x_scale    <= i_cfg_data[SCALE_WIDTH-1:0];
               4'd6:    r_sh_y_scale    <= i_cfg_data[SCALE_WIDTH-1:0];
               4'd7:    r_sh_left       <= i_cfg_data[LeftOffsetWidth-1:0];
               4'd8:    r_sh_top        <= i_cfg_data[SCALE_WIDTH-1:0];
               4'd9:    r_sh_nn         <= i_cfg_data[0];
               4'd10:   r_sh_start_wait <= i_cfg_data[BLANK_WIDTH-1:0];
               4'd11:   r_sh_h_blank    <= i_cfg_data[BLANK_WIDTH-1:0];
               default: ;
            endcase
         end

         // Copy uses the pre-edge shadow, so a same-cycle write only reaches the shadow.
         if (w_apply) begin
            r_cfg_valid      <= 1'b1;
            r_act_discard    <= r_sh_discard;
            r_act_in_x       <= r_sh_in_x;
            r_act_in_y       <= r_sh_in_y;
            r_act_out_x      <= r_sh_out_x;
            r_act_out_y      <= r_sh_out_y;
            r_act_x_scale    <= r_sh_x_scale;
            r_act_y_scale    <= r_sh_y_scale;
            r_act_left       <= r_sh_left;
            r_act_top        <= r_sh_top;
            r_act_nn         <= r_sh_nn;
            r_act_start_wait <= r_sh_start_wait;
            r_act_h_blank    <= r_sh_h_blank;
         end
      end
   end

   assign o_input_discard_cnt = r_act_discard;
   assign o_input_x_res       = r_act_in_x;
   assign o_input_y_res       = r_act_in_y;
   assign o_output_x_res      = r_act_out_x;
   assign o_output_y_res      = r_act_out_y;
   assign o_x_scale           = r_act_x_scale;
   assign o_y_scale           = r_act_y_scale;
   assign o_left_offset       = r_act_left;
   assign o_top_frac_offset   = r_act_top;
   assign o_nearest_neighbor  = r_act_nn;
   assign o_next_dout         = r_next_dout;
   assign o_busy              = (r_state != StIdle);
   assign o_commit_pending    = r_commit_pending;

endmodule
